// File: rtl/pwm_multi_pkg.sv
// Shared constants and helpers for the multi-channel PWM generator.
package pwm_multi_pkg;

    localparam int PWM_EDGE   = 0;
    localparam int PWM_CENTER = 1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    function automatic int unsigned pwm_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/pwm_multi_timebase.sv
// Shared period counter: prescaler, up or up/down count, period boundary strobe.
// dir     | meaning
// DIR_UP  | counting toward MAX (edge mode stays here)
// DIR_DOWN| center mode, counting back toward 0
module pwm_multi_timebase
    import pwm_multi_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int CENTER = PWM_EDGE,
    parameter int DIV    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             boundary
);

    localparam logic [WIDTH-1:0] CNT_MAX    = WIDTH'(pwm_max(WIDTH));
    localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);
    localparam logic [15:0]      PRESC_LAST = 16'(DIV - 1);

    logic [15:0]      presc_q, presc_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    dir_e             dir_q, dir_d;
    logic             tick;

    always_comb begin
        presc_d  = presc_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        tick     = 1'b0;
        boundary = 1'b0;
        if (!en) begin
            presc_d = '0;
            cnt_d   = '0;
            dir_d   = DIR_UP;
        end else begin
            tick    = (presc_q == PRESC_LAST);
            presc_d = tick ? '0 : presc_q + 16'd1;
            if (tick) begin
                if (CENTER == PWM_EDGE) begin
                    cnt_d    = cnt_q + CNT_ONE;
                    boundary = (cnt_q == CNT_MAX);
                end else if (dir_q == DIR_UP) begin
                    cnt_d = cnt_q + CNT_ONE;
                    // turn around as MAX is reached so MAX is visited only once
                    if (cnt_d == CNT_MAX) dir_d = DIR_DOWN;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        dir_d    = DIR_UP;
                        boundary = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            cnt_q   <= '0;
            dir_q   <= DIR_UP;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared timebase, per-channel double-buffered duty
// that switches only on a period boundary.
module pwm_multi
    import pwm_multi_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int CENTER   = PWM_EDGE,
    parameter int DIV      = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      load,
    input  logic [CHANNELS*WIDTH-1:0] value,
    output logic [CHANNELS-1:0]       pwm,
    output logic                      period_start,
    output logic                      pending
);

    typedef logic [CHANNELS-1:0][WIDTH-1:0] duty_t;

    duty_t                shadow_q, shadow_d;
    duty_t                active_q, active_d;
    logic                 pending_q, pending_d;
    logic [CHANNELS-1:0]  pwm_q, pwm_d;
    logic                 period_start_q, period_start_d;
    logic [WIDTH-1:0]     cnt;
    logic                 boundary;

    pwm_multi_timebase #(
        .WIDTH  (WIDTH),
        .CENTER (CENTER),
        .DIV    (DIV)
    ) u_timebase (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .cnt      (cnt),
        .boundary (boundary)
    );

    always_comb begin
        shadow_d       = shadow_q;
        active_d       = active_q;
        pending_d      = pending_q;
        period_start_d = boundary;
        if (load) shadow_d = value;
        if (!en) begin
            // a load while idle goes straight to active so the first period after en uses it
            active_d  = load ? duty_t'(value) : shadow_q;
            pending_d = 1'b0;
        end else if (load) begin
            if (boundary) begin
                active_d  = value;
                pending_d = 1'b0;
            end else begin
                pending_d = 1'b1;
            end
        end else if (boundary && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_cmp
        assign pwm_d[i] = en & (cnt < active_q[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q       <= '0;
            active_q       <= '0;
            pending_q      <= 1'b0;
            pwm_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            shadow_q       <= shadow_d;
            active_q       <= active_d;
            pending_q      <= pending_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
        end
    end

    assign pwm          = pwm_q;
    assign period_start = period_start_q;
    assign pending      = pending_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: edge mode W=8, center mode W=4 with DIV=1 and DIV=3.
module tb_pwm_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_e, load_e;
    logic [31:0] value_e;
    logic [3:0]  pwm_e;
    logic        ps_e, pend_e;
    logic        en_c, load_c;
    logic [3:0]  value_c;
    logic        pwm_c1, ps_c1, pend_c1;
    logic        pwm_c3, ps_c3, pend_c3;

    always #5 clk = ~clk;

    pwm_multi #(.CHANNELS(4), .WIDTH(8), .CENTER(0), .DIV(1)) u_edge (
        .clk(clk), .rst(rst), .en(en_e), .load(load_e), .value(value_e),
        .pwm(pwm_e), .period_start(ps_e), .pending(pend_e));

    pwm_multi #(.CHANNELS(1), .WIDTH(4), .CENTER(1), .DIV(1)) u_c1 (
        .clk(clk), .rst(rst), .en(en_c), .load(load_c), .value(value_c),
        .pwm(pwm_c1), .period_start(ps_c1), .pending(pend_c1));

    pwm_multi #(.CHANNELS(1), .WIDTH(4), .CENTER(1), .DIV(3)) u_c3 (
        .clk(clk), .rst(rst), .en(en_c), .load(load_c), .value(value_c),
        .pwm(pwm_c3), .period_start(ps_c3), .pending(pend_c3));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int hi [4];
    int ps_cnt, ps_last, pend_a, pend_b, pend_end;

    // Samples n cycles; sample j shows pwm for counter value j-1 when started at a boundary.
    // Optional loads are driven right after samples ld_a / ld_b.
    task automatic run_edge(input int n, input int ld_a, input logic [31:0] val_a,
                            input int ld_b, input logic [31:0] val_b);
        for (int c = 0; c < 4; c++) hi[c] = 0;
        ps_cnt = 0;
        pend_a = -1;
        pend_b = -1;
        for (int j = 1; j <= n; j++) begin
            @(negedge clk);
            load_e = 1'b0;
            for (int c = 0; c < 4; c++) hi[c] += int'(pwm_e[c]);
            ps_cnt += int'(ps_e);
            if (j == ld_a + 1) pend_a = int'(pend_e);
            if (j == ld_b + 1) pend_b = int'(pend_e);
            if (j == ld_a) begin load_e = 1'b1; value_e = val_a; end
            if (j == ld_b) begin load_e = 1'b1; value_e = val_b; end
        end
        ps_last  = int'(ps_e);
        pend_end = int'(pend_e);
    endtask

    task automatic chk_hi(input string tag, input int e0, input int e1, input int e2, input int e3);
        chk({tag, "_ch0"}, hi[0], e0);
        chk({tag, "_ch1"}, hi[1], e1);
        chk({tag, "_ch2"}, hi[2], e2);
        chk({tag, "_ch3"}, hi[3], e3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, c_hi, c_ps, s1, s16, s30;
        rst = 1'b1; en_e = 1'b0; load_e = 1'b0; value_e = '0;
        en_c = 1'b0; load_c = 1'b0; value_c = '0;
        repeat (3) @(negedge clk);

        // reset must override a concurrent load and enable
        en_e = 1'b1; load_e = 1'b1; value_e = {8'd255, 8'd0, 8'd1, 8'd30};
        @(negedge clk);
        chk("rst_pwm", int'(pwm_e), 0);
        chk("rst_ps", int'(ps_e), 0);
        chk("rst_pend", int'(pend_e), 0);

        rst = 1'b0; en_e = 1'b0;
        @(negedge clk);
        load_e = 1'b0;
        chk("idle_load_pend", int'(pend_e), 0);
        en_e = 1'b1;

        run_edge(256, -10, '0, -10, '0);
        chk_hi("p1", 30, 1, 0, 255);
        chk("p1_ps_cnt", ps_cnt, 1);
        chk("p1_ps_last", ps_last, 1);

        run_edge(256, 100, {8'd255, 8'd0, 8'd1, 8'd15}, -10, '0);
        chk_hi("p2", 30, 1, 0, 255);
        chk("p2_pend_set", pend_a, 1);
        chk("p2_pend_clr", pend_end, 0);

        run_edge(256, 255, {8'd255, 8'd0, 8'd1, 8'd7}, -10, '0);
        chk("p3_ch0", hi[0], 15);
        chk("p3_pend_bnd", pend_a, 0);

        run_edge(256, 50, {8'd255, 8'd0, 8'd1, 8'd20}, 150, {8'd255, 8'd0, 8'd1, 8'd40});
        chk("p4_ch0", hi[0], 7);
        chk("p4_pend_set", pend_a, 1);
        chk("p4_pend_clr", pend_end, 0);

        run_edge(256, -10, '0, -10, '0);
        chk_hi("p5", 40, 1, 0, 255);
        chk("p5_ps_cnt", ps_cnt, 1);

        // drop enable mid-period, load while idle, restart
        repeat (10) @(negedge clk);
        en_e = 1'b0;
        @(negedge clk);
        chk("en_off_pwm", int'(pwm_e), 0);
        chk("en_off_ps", int'(ps_e), 0);
        load_e = 1'b1; value_e = {8'd255, 8'd0, 8'd1, 8'd9};
        @(negedge clk);
        load_e = 1'b0;
        @(negedge clk);
        chk("en_off_pend", int'(pend_e), 0);
        en_e = 1'b1;
        run_edge(256, -10, '0, -10, '0);
        chk_hi("p6", 9, 1, 0, 255);
        chk("p6_ps_cnt", ps_cnt, 1);
        chk("p6_ps_last", ps_last, 1);

        // reset in the middle of a pulse with a load pending
        repeat (3) @(negedge clk);
        chk("pre_rst_ch0", int'(pwm_e[0]), 1);
        load_e = 1'b1; value_e = {8'd100, 8'd100, 8'd100, 8'd50};
        @(negedge clk);
        load_e = 1'b0;
        chk("pre_rst_pend", int'(pend_e), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_pwm", int'(pwm_e), 0);
        chk("mid_rst_pend", int'(pend_e), 0);
        chk("mid_rst_ps", int'(ps_e), 0);
        rst = 1'b0;
        run_edge(600, -10, '0, -10, '0);
        chk("post_rst_hi", hi[0] + hi[1] + hi[2] + hi[3], 0);
        chk("post_rst_pend", pend_end, 0);

        // center mode, W=4 (MAX=15): period 30 ticks, cnt<5 on 9 of them
        load_c = 1'b1; value_c = 4'd5;
        @(negedge clk);
        load_c = 1'b0;
        chk("c_idle_pend1", int'(pend_c1), 0);
        chk("c_idle_pend3", int'(pend_c3), 0);
        en_c = 1'b1;

        k = 0;
        do begin @(negedge clk); k++; end while (ps_c1 !== 1'b1 && k < 100);
        chk("c1_ps_seen", int'(ps_c1), 1);
        c_hi = 0; c_ps = 0; s1 = 0; s16 = 0; s30 = 0;
        for (int j = 1; j <= 30; j++) begin
            @(negedge clk);
            c_hi += int'(pwm_c1);
            c_ps += int'(ps_c1);
            if (j == 1)  s1  = int'(pwm_c1);
            if (j == 16) s16 = int'(pwm_c1);
            if (j == 30) s30 = int'(pwm_c1);
        end
        chk("c1_hi", c_hi, 9);
        chk("c1_ps_cnt", c_ps, 1);
        chk("c1_at_cnt0", s1, 1);
        chk("c1_at_max", s16, 0);
        chk("c1_at_cnt1_down", s30, 1);
        chk("c1_ps_last", int'(ps_c1), 1);

        k = 0;
        do begin @(negedge clk); k++; end while (ps_c3 !== 1'b1 && k < 300);
        chk("c3_ps_seen", int'(ps_c3), 1);
        c_hi = 0; c_ps = 0;
        for (int j = 1; j <= 90; j++) begin
            @(negedge clk);
            c_hi += int'(pwm_c3);
            c_ps += int'(ps_c3);
        end
        chk("c3_hi", c_hi, 27);
        chk("c3_ps_cnt", c_ps, 1);
        chk("c3_ps_last", int'(ps_c3), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
